// File: rtl/cci_mpf_shim_lockstep_deq_ctrl.sv
// Lockstep c0/c1 Tx issue scheduler for an MPF shim.
// The buffer head (c0 read and c1 write/fence together) is dequeued only when
// every valid channel can be accepted by the FIU. In-flight reads and writes
// are counted for credit limits, write fences and the quiesce handshake.
module cci_mpf_shim_lockstep_deq_ctrl #(
    parameter int MAX_RD_OUTSTANDING = 256,
    parameter int MAX_WR_OUTSTANDING = 256,
    parameter int STALL_CNT_BITS     = 32,
    localparam int RD_CNT_BITS       = $clog2(MAX_RD_OUTSTANDING + 1),
    localparam int WR_CNT_BITS       = $clog2(MAX_WR_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      head_c0_valid,
    input  logic                      head_c1_valid,
    input  logic                      head_c1_fence,
    input  logic                      fiu_c0_alm_full,
    input  logic                      fiu_c1_alm_full,
    input  logic                      rd_rsp_valid,
    input  logic [2:0]                wr_rsp_cnt,
    input  logic                      quiesce_req,
    output logic                      deqTx,
    output logic [RD_CNT_BITS-1:0]    rd_outstanding,
    output logic [WR_CNT_BITS-1:0]    wr_outstanding,
    output logic                      quiesced,
    output logic                      fence_wait,
    output logic [STALL_CNT_BITS-1:0] stall_cycles,
    output logic                      err_underflow
);

    // Write arithmetic must be wide enough for both wr+1 and a 3-bit response count.
    localparam int WR_SUM_BITS = (WR_CNT_BITS + 1 > 3) ? WR_CNT_BITS + 1 : 3;

    localparam logic [RD_CNT_BITS-1:0] RD_MAX = RD_CNT_BITS'(MAX_RD_OUTSTANDING);
    localparam logic [WR_CNT_BITS-1:0] WR_MAX = WR_CNT_BITS'(MAX_WR_OUTSTANDING);

    typedef enum logic [1:0] {
        S_RUN,
        S_QDRAIN,
        S_QUIESCED
    } state_t;

    state_t state;

    logic                   head_any;
    logic                   ok0;
    logic                   ok1;
    logic                   issue_rd;
    logic                   issue_wr;
    logic [RD_CNT_BITS:0]   rd_sum;
    logic [RD_CNT_BITS:0]   rd_sub;
    logic                   rd_underflow;
    logic [RD_CNT_BITS-1:0] rd_next;
    logic [WR_SUM_BITS-1:0] wr_sum;
    logic [WR_SUM_BITS-1:0] wr_sub;
    logic                   wr_underflow;
    logic [WR_CNT_BITS-1:0] wr_next;

    // Channel acceptance and lockstep dequeue decision (zero-cycle path from head/alm_full).
    always_comb begin
        head_any = head_c0_valid | head_c1_valid;
        ok0 = !head_c0_valid |
              (!fiu_c0_alm_full & (rd_outstanding < RD_MAX));
        ok1 = !head_c1_valid |
              (!fiu_c1_alm_full & (wr_outstanding < WR_MAX) &
               (!head_c1_fence | (wr_outstanding == '0)));
        // quiesce_req gates the cycle it rises, before the state has moved to QDRAIN.
        deqTx = reset_n & (state == S_RUN) & !quiesce_req & head_any & ok0 & ok1;
        issue_rd = deqTx & head_c0_valid;
        issue_wr = deqTx & head_c1_valid;
        fence_wait = (state == S_RUN) & head_c1_valid & head_c1_fence &
                     (wr_outstanding != '0);
    end

    // Next in-flight counts: issue and response net out, saturating at zero.
    always_comb begin
        rd_sum       = {1'b0, rd_outstanding} + {{RD_CNT_BITS{1'b0}}, issue_rd};
        rd_sub       = {{RD_CNT_BITS{1'b0}}, rd_rsp_valid};
        rd_underflow = rd_sum < rd_sub;
        rd_next      = rd_underflow ? '0 : RD_CNT_BITS'(rd_sum - rd_sub);

        wr_sum       = WR_SUM_BITS'(wr_outstanding) + WR_SUM_BITS'(issue_wr);
        wr_sub       = WR_SUM_BITS'(wr_rsp_cnt);
        wr_underflow = wr_sum < wr_sub;
        wr_next      = wr_underflow ? '0 : WR_CNT_BITS'(wr_sum - wr_sub);
    end

    // Quiesce state machine with registered quiesced flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_RUN;
            quiesced <= 1'b0;
        end else begin
            quiesced <= (state == S_QUIESCED) & quiesce_req;
            if (!quiesce_req) begin
                state <= S_RUN;
            end else begin
                case (state)
                    S_RUN:    state <= S_QDRAIN;
                    S_QDRAIN: if (rd_next == '0 && wr_next == '0) state <= S_QUIESCED;
                    default:  state <= state;
                endcase
            end
        end
    end

    // In-flight counters and sticky underflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_outstanding <= '0;
            wr_outstanding <= '0;
            err_underflow  <= 1'b0;
        end else begin
            rd_outstanding <= rd_next;
            wr_outstanding <= wr_next;
            if (rd_underflow || wr_underflow) err_underflow <= 1'b1;
        end
    end

    // Saturating count of cycles a non-empty head was held back while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (head_any && !deqTx && state == S_RUN && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + STALL_CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_cci_mpf_shim_lockstep_deq_ctrl.sv
// Self-checking bench for the lockstep dequeue controller: directed scenarios
// plus randomized traffic compared against a cycle-level reference model.
module tb_cci_mpf_shim_lockstep_deq_ctrl;

    localparam int MAXR = 2;
    localparam int MAXW = 4;
    localparam int SB   = 6;
    localparam int RB   = 2;
    localparam int WB   = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          head_c0_valid = 1'b0;
    logic          head_c1_valid = 1'b0;
    logic          head_c1_fence = 1'b0;
    logic          fiu_c0_alm_full = 1'b0;
    logic          fiu_c1_alm_full = 1'b0;
    logic          rd_rsp_valid = 1'b0;
    logic [2:0]    wr_rsp_cnt = 3'd0;
    logic          quiesce_req = 1'b0;
    logic          deqTx;
    logic [RB-1:0] rd_outstanding;
    logic [WB-1:0] wr_outstanding;
    logic          quiesced;
    logic          fence_wait;
    logic [SB-1:0] stall_cycles;
    logic          err_underflow;

    always #5 clk = ~clk;

    cci_mpf_shim_lockstep_deq_ctrl #(
        .MAX_RD_OUTSTANDING(MAXR),
        .MAX_WR_OUTSTANDING(MAXW),
        .STALL_CNT_BITS(SB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .head_c0_valid(head_c0_valid),
        .head_c1_valid(head_c1_valid),
        .head_c1_fence(head_c1_fence),
        .fiu_c0_alm_full(fiu_c0_alm_full),
        .fiu_c1_alm_full(fiu_c1_alm_full),
        .rd_rsp_valid(rd_rsp_valid),
        .wr_rsp_cnt(wr_rsp_cnt),
        .quiesce_req(quiesce_req),
        .deqTx(deqTx),
        .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding),
        .quiesced(quiesced),
        .fence_wait(fence_wait),
        .stall_cycles(stall_cycles),
        .err_underflow(err_underflow)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: in-flight counts, quiesce phase (0 run, 1 draining, 2 quiet)
    int m_rd, m_wr, m_phase, m_stall;
    bit m_q, m_err;
    bit exp_deq, exp_fw;
    logic obs_deq, obs_fw;

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_phase = 0; m_stall = 0; m_q = 0; m_err = 0;
    endtask

    task automatic drive(input bit c0, input bit c1, input bit f, input bit a0, input bit a1,
                         input bit rr, input int wr, input bit q);
        head_c0_valid = c0; head_c1_valid = c1; head_c1_fence = f;
        fiu_c0_alm_full = a0; fiu_c1_alm_full = a1;
        rd_rsp_valid = rr; wr_rsp_cnt = 3'(wr); quiesce_req = q;
    endtask

    // Advance one clock: predict combinational outputs, sample the DUT's, then update the model.
    task automatic step();
        bit ok0, ok1;
        int nr, nw;
        ok0 = !head_c0_valid || (!fiu_c0_alm_full && m_rd < MAXR);
        ok1 = !head_c1_valid || (!fiu_c1_alm_full && m_wr < MAXW && (!head_c1_fence || m_wr == 0));
        exp_deq = (m_phase == 0) && !quiesce_req && (head_c0_valid || head_c1_valid) && ok0 && ok1;
        exp_fw  = (m_phase == 0) && head_c1_valid && head_c1_fence && (m_wr != 0);
        #2;
        obs_deq = deqTx;
        obs_fw  = fence_wait;
        @(posedge clk);
        nr = m_rd + ((exp_deq && head_c0_valid) ? 1 : 0) - (rd_rsp_valid ? 1 : 0);
        nw = m_wr + ((exp_deq && head_c1_valid) ? 1 : 0) - int'(wr_rsp_cnt);
        if (nr < 0) begin nr = 0; m_err = 1; end
        if (nw < 0) begin nw = 0; m_err = 1; end
        if (m_phase == 0 && (head_c0_valid || head_c1_valid) && !exp_deq && m_stall < (1 << SB) - 1)
            m_stall++;
        m_q = (m_phase == 2) && quiesce_req;
        if (!quiesce_req) m_phase = 0;
        else if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1 && nr == 0 && nw == 0) m_phase = 2;
        m_rd = nr;
        m_wr = nw;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && (m_rd != 0 || m_wr != 0); i++) begin
            drive(0, 0, 0, 0, 0, m_rd > 0, (m_wr > 4) ? 4 : m_wr, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (deqTx !== 1'b0) begin failures++; $display("FAIL reset_deq got=%b exp=0", deqTx); end
        checks++;
        if (rd_outstanding !== '0 || wr_outstanding !== '0) begin
            failures++; $display("FAIL reset_counts got rd=%0d wr=%0d exp 0 0", rd_outstanding, wr_outstanding);
        end
        checks++;
        if (quiesced !== 1'b0 || fence_wait !== 1'b0 || stall_cycles !== '0 || err_underflow !== 1'b0) begin
            failures++; $display("FAIL reset_flags got q=%b fw=%b st=%0d err=%b exp all 0",
                                 quiesced, fence_wait, stall_cycles, err_underflow);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_issue();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (obs_deq !== 1'b1 || obs_deq !== exp_deq) begin failures++; $display("FAIL issue_deq got=%b exp=1", obs_deq); end
        checks++;
        if (rd_outstanding !== 2'(m_rd) || wr_outstanding !== 3'(m_wr) || m_rd != 1 || m_wr != 1) begin
            failures++; $display("FAIL issue_counts got rd=%0d wr=%0d exp 1 1", rd_outstanding, wr_outstanding);
        end
        drain();
    endtask

    task automatic test_lockstep();
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs_deq !== 1'b0 || rd_outstanding !== '0) begin
                failures++; $display("FAIL lockstep_hold cyc=%0d got deq=%b rd=%0d exp 0 0", i, obs_deq, rd_outstanding);
            end
            checks++;
            if (stall_cycles !== 6'(m_stall)) begin
                failures++; $display("FAIL lockstep_stall cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_stall);
            end
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (obs_deq !== 1'b1) begin failures++; $display("FAIL lockstep_release got=%b exp=1", obs_deq); end
        drain();
    endtask

    task automatic test_rd_credit();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_deq !== exp_deq || exp_deq != (i < 2)) begin
                failures++; $display("FAIL rd_credit_deq n=%0d got=%b exp=%b", i, obs_deq, exp_deq);
            end
        end
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        step();
        checks++;
        if (obs_deq !== 1'b0 || rd_outstanding !== 2'd1) begin
            failures++; $display("FAIL rd_credit_rsp got deq=%b rd=%0d exp 0 1", obs_deq, rd_outstanding);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (obs_deq !== 1'b1 || rd_outstanding !== 2'(m_rd) || m_rd != 2) begin
            failures++; $display("FAIL rd_credit_resume got deq=%b rd=%0d exp 1 2", obs_deq, rd_outstanding);
        end
        drain();
    endtask

    task automatic test_fence();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (obs_fw !== 1'b1 || obs_deq !== 1'b0 || wr_outstanding !== 3'd3) begin
            failures++; $display("FAIL fence_block got fw=%b deq=%b wr=%0d exp 1 0 3", obs_fw, obs_deq, wr_outstanding);
        end
        drive(0, 1, 1, 0, 0, 0, 3, 0);
        step();
        checks++;
        if (obs_deq !== 1'b0 || wr_outstanding !== 3'd0) begin
            failures++; $display("FAIL fence_drain got deq=%b wr=%0d exp 0 0", obs_deq, wr_outstanding);
        end
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (obs_deq !== 1'b1 || obs_fw !== 1'b0 || wr_outstanding !== 3'd1) begin
            failures++; $display("FAIL fence_issue got deq=%b fw=%b wr=%0d exp 1 0 1", obs_deq, obs_fw, wr_outstanding);
        end
        drain();
    endtask

    task automatic test_quiesce();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        step();
        checks++;
        if (obs_deq !== 1'b0) begin failures++; $display("FAIL quiesce_gate_first got=%b exp=0", obs_deq); end
        step();
        checks++;
        if (obs_deq !== 1'b0 || quiesced !== 1'b0) begin
            failures++; $display("FAIL quiesce_drain got deq=%b q=%b exp 0 0", obs_deq, quiesced);
        end
        drive(1, 1, 0, 0, 0, 1, 2, 1);
        step();
        checks++;
        if (rd_outstanding !== '0 || wr_outstanding !== '0 || quiesced !== 1'b0) begin
            failures++; $display("FAIL quiesce_zero got rd=%0d wr=%0d q=%b exp 0 0 0", rd_outstanding, wr_outstanding, quiesced);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        step();
        checks++;
        if (quiesced !== 1'b1 || m_q != 1) begin failures++; $display("FAIL quiesce_assert got=%b exp=1", quiesced); end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (quiesced !== 1'b0 || obs_deq !== 1'b0) begin
            failures++; $display("FAIL quiesce_exit got q=%b deq=%b exp 0 0", quiesced, obs_deq);
        end
        step();
        checks++;
        if (obs_deq !== 1'b1) begin failures++; $display("FAIL quiesce_resume got=%b exp=1", obs_deq); end
        drain();
    endtask

    task automatic test_underflow_reset();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 2, 0);
        step();
        checks++;
        if (wr_outstanding !== 3'd0 || err_underflow !== 1'b1 || m_err != 1) begin
            failures++; $display("FAIL underflow_set got wr=%0d err=%b exp 0 1", wr_outstanding, err_underflow);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        checks++;
        if (err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (deqTx !== 1'b0 || rd_outstanding !== '0 || wr_outstanding !== '0 ||
            err_underflow !== 1'b0 || stall_cycles !== '0 || quiesced !== 1'b0) begin
            failures++; $display("FAIL midreset got deq=%b rd=%0d wr=%0d err=%b st=%0d q=%b exp all 0",
                                 deqTx, rd_outstanding, wr_outstanding, err_underflow, stall_cycles, quiesced);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall_sat();
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        repeat (70) step();
        checks++;
        if (stall_cycles !== 6'h3f || m_stall != 63) begin
            failures++; $display("FAIL stall_saturate got=%0d exp=63", stall_cycles);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (stall_cycles !== 6'h3f || obs_deq !== 1'b0) begin
            failures++; $display("FAIL stall_empty got st=%0d deq=%b exp 63 0", stall_cycles, obs_deq);
        end
    endtask

    task automatic test_random();
        bit q = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) q = ~q;
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  (m_rd > 0) && $urandom_range(0, 2) == 0,
                  $urandom_range(0, (m_wr > 4) ? 4 : m_wr), q);
            step();
            checks++;
            if (obs_deq !== exp_deq) begin failures++; $display("FAIL rand_deq cyc=%0d got=%b exp=%b", i, obs_deq, exp_deq); end
            checks++;
            if (obs_fw !== exp_fw) begin failures++; $display("FAIL rand_fence_wait cyc=%0d got=%b exp=%b", i, obs_fw, exp_fw); end
            checks++;
            if (rd_outstanding !== 2'(m_rd)) begin failures++; $display("FAIL rand_rd cyc=%0d got=%0d exp=%0d", i, rd_outstanding, m_rd); end
            checks++;
            if (wr_outstanding !== 3'(m_wr)) begin failures++; $display("FAIL rand_wr cyc=%0d got=%0d exp=%0d", i, wr_outstanding, m_wr); end
            checks++;
            if (quiesced !== m_q) begin failures++; $display("FAIL rand_quiesced cyc=%0d got=%b exp=%b", i, quiesced, m_q); end
            checks++;
            if (stall_cycles !== 6'(m_stall)) begin failures++; $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_stall); end
            checks++;
            if (err_underflow !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", i, err_underflow, m_err); end
        end
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_issue();
        test_lockstep();
        test_rd_credit();
        test_fence();
        test_quiesce();
        test_underflow_reset();
        test_stall_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
